// File: rtl/output_buffer_ctrl.sv
// Output buffer sequencer: fills the per-lane register files row-major, then drains them as 2x2 windows.
// Build option OB_CTRL_PINGPONG_EN: two banks, fill and drain run concurrently.
//
// state   | meaning
// IDLE    | waiting for start (serial build)
// FILL    | accepting one map element per handshake
// DRAIN   | presenting window addresses to the pooling stage
// DONE    | one-cycle completion pulse
module output_buffer_ctrl #(
    parameter int WIDTH   = 32,
    parameter int ADDR_W  = 5,
    parameter int MAP_DIM = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WIDTH-1:0]  lane_en,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [WIDTH-1:0]  Wr_ctrl,
    output logic [ADDR_W-1:0] add_in,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [ADDR_W-1:0] add_1,
    output logic [ADDR_W-1:0] add_2,
    output logic [ADDR_W-1:0] add_3,
    output logic [ADDR_W-1:0] add_4,
    output logic              win_last,
    output logic              busy,
    output logic              done
);

    localparam int N_ELEM = MAP_DIM * MAP_DIM;
    localparam logic [ADDR_W-1:0] LAST_ELEM = ADDR_W'(N_ELEM - 1);
    localparam logic [ADDR_W-1:0] LAST_WIN  = ADDR_W'(MAP_DIM / 2 - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(2 * MAP_DIM);
    localparam logic [ADDR_W-1:0] COL_STEP  = ADDR_W'(MAP_DIM);
    localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);

    logic [WIDTH-1:0]  lane_q;
    logic [ADDR_W-1:0] wr_cnt, add_in_q, fill_off;
    logic [ADDR_W-1:0] win_r, win_c, drain_off, load_off;
    logic [ADDR_W-1:0] nxt_r, nxt_c, nxt_off, nxt_base;
    logic [ADDR_W-1:0] a1_q, a2_q, a3_q, a4_q;
    logic              fill_active, drain_active;
    logic              fill_start, fire, fill_done;
    logic              drain_load, drain_hs, drain_step, last_win;

    assign fire       = fill_active && in_valid;
    assign fill_done  = fire && (wr_cnt == LAST_ELEM);
    assign last_win   = (win_r == LAST_WIN) && (win_c == LAST_WIN);
    assign drain_hs   = drain_active && rd_ready;
    assign drain_step = drain_hs && !last_win;

    assign Wr_ctrl  = fire ? lane_q : '0;
    assign add_in   = fire ? (fill_off + wr_cnt) : add_in_q;
    assign add_1    = a1_q;
    assign add_2    = a2_q;
    assign add_3    = a3_q;
    assign add_4    = a4_q;
    assign win_last = drain_active && last_win;

    always_ff @(posedge clk) begin
        if (rst) begin
            lane_q   <= '0;
            wr_cnt   <= '0;
            add_in_q <= '0;
        end else if (fill_start) begin
            lane_q <= lane_en;
            wr_cnt <= '0;
        end else if (fire) begin
            wr_cnt   <= wr_cnt + ONE;
            add_in_q <= fill_off + wr_cnt;
        end
    end

    // Next window is either the first of a fresh bank or the row-major successor.
    always_comb begin
        nxt_r   = '0;
        nxt_c   = '0;
        nxt_off = load_off;
        if (!drain_load) begin
            nxt_off = drain_off;
            if (win_c == LAST_WIN) begin
                nxt_r = win_r + ONE;
            end else begin
                nxt_r = win_r;
                nxt_c = win_c + ONE;
            end
        end
        nxt_base = nxt_off + nxt_r * ROW_STEP + nxt_c + nxt_c;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            win_r     <= '0;
            win_c     <= '0;
            drain_off <= '0;
            a1_q      <= '0;
            a2_q      <= '0;
            a3_q      <= '0;
            a4_q      <= '0;
        end else if (drain_load || drain_step) begin
            win_r     <= nxt_r;
            win_c     <= nxt_c;
            drain_off <= nxt_off;
            a1_q      <= nxt_base;
            a2_q      <= nxt_base + ONE;
            a3_q      <= nxt_base + COL_STEP;
            a4_q      <= nxt_base + COL_STEP + ONE;
        end
    end

`ifdef OB_CTRL_PINGPONG_EN
    localparam logic [ADDR_W-1:0] BANK_OFF = ADDR_W'(N_ELEM);

    typedef enum logic [1:0] {D_IDLE, D_DRAIN, D_DONE} dstate_t;
    dstate_t    dstate_q, dstate_d;
    logic       fill_act_q, fill_bank_q, fill_ptr_q;
    logic       drain_bank_q, drain_ptr_q;
    logic [1:0] bank_full_q;

    assign fill_active  = fill_act_q;
    assign drain_active = (dstate_q == D_DRAIN);
    assign fill_start   = start && !fill_act_q && !bank_full_q[fill_ptr_q];
    assign fill_off     = fill_bank_q ? BANK_OFF : '0;
    // A bank finishing its fill this cycle can start draining straight away.
    assign drain_load   = (dstate_q == D_IDLE) &&
                          (bank_full_q[drain_ptr_q] || (fill_done && (fill_bank_q == drain_ptr_q)));
    assign load_off     = drain_ptr_q ? BANK_OFF : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            dstate_q     <= D_IDLE;
            fill_act_q   <= 1'b0;
            fill_bank_q  <= 1'b0;
            fill_ptr_q   <= 1'b0;
            drain_bank_q <= 1'b0;
            drain_ptr_q  <= 1'b0;
            bank_full_q  <= '0;
        end else begin
            dstate_q <= dstate_d;
            if (fill_start) begin
                fill_act_q  <= 1'b1;
                fill_bank_q <= fill_ptr_q;
                fill_ptr_q  <= !fill_ptr_q;
            end else if (fill_done) begin
                fill_act_q <= 1'b0;
            end
            if (drain_load) begin
                drain_bank_q <= drain_ptr_q;
                drain_ptr_q  <= !drain_ptr_q;
            end
            if (fill_done)
                bank_full_q[fill_bank_q] <= 1'b1;
            if (drain_hs && last_win)
                bank_full_q[drain_bank_q] <= 1'b0;
        end
    end

    always_comb begin
        dstate_d = dstate_q;
        in_ready = fill_act_q;
        rd_valid = 1'b0;
        done     = 1'b0;
        busy     = fill_act_q || (dstate_q != D_IDLE) || (|bank_full_q);
        case (dstate_q)
            D_IDLE:  if (drain_load) dstate_d = D_DRAIN;
            D_DRAIN: begin
                rd_valid = 1'b1;
                if (rd_ready && last_win) dstate_d = D_DONE;
            end
            D_DONE: begin
                done     = 1'b1;
                dstate_d = D_IDLE;
            end
            default: dstate_d = D_IDLE;
        endcase
    end
`else
    typedef enum logic [1:0] {S_IDLE, S_FILL, S_DRAIN, S_DONE} state_t;
    state_t state_q, state_d;

    assign fill_active  = (state_q == S_FILL);
    assign drain_active = (state_q == S_DRAIN);
    assign fill_start   = (state_q == S_IDLE) && start;
    assign fill_off     = '0;
    assign drain_load   = fill_done;
    assign load_off     = '0;

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        rd_valid = 1'b0;
        done     = 1'b0;
        busy     = 1'b1;
        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_d = S_FILL;
            end
            S_FILL: begin
                in_ready = 1'b1;
                if (fill_done) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                rd_valid = 1'b1;
                if (rd_ready && last_win) state_d = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end
`endif

endmodule

// File: tb/tb_output_buffer_ctrl.sv
// Bench for output_buffer_ctrl: vector table, directed corner sequences and randomized traffic
// checked against a transaction-level reference model.
module tb_output_buffer_ctrl;
    localparam int WIDTH   = 32;
    localparam int ADDR_W  = 5;
    localparam int MAP_DIM = 4;
    localparam int N_ELEM  = MAP_DIM * MAP_DIM;
    localparam int NW      = MAP_DIM / 2;
    localparam int N_WIN   = NW * NW;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic              rd_ready = 1'b0;
    logic [WIDTH-1:0]  lane_en = '0;
    logic              in_ready, rd_valid, win_last, busy, done;
    logic [WIDTH-1:0]  Wr_ctrl;
    logic [ADDR_W-1:0] add_in, add_1, add_2, add_3, add_4;

    always #5 clk = ~clk;

    output_buffer_ctrl #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .MAP_DIM(MAP_DIM)) dut (
        .clk(clk), .rst(rst), .start(start), .lane_en(lane_en),
        .in_valid(in_valid), .in_ready(in_ready), .Wr_ctrl(Wr_ctrl), .add_in(add_in),
        .rd_valid(rd_valid), .rd_ready(rd_ready),
        .add_1(add_1), .add_2(add_2), .add_3(add_3), .add_4(add_4),
        .win_last(win_last), .busy(busy), .done(done)
    );

    int checks = 0;
    int failures = 0;
    int dut_writes = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: phase of the transaction plus element/window counts.
    int          m_phase;   // 0 idle, 1 fill, 2 drain, 3 done
    logic [31:0] m_lanes;
    int          m_nwr, m_last_add, m_k;
    bit          m_clean;

    task automatic model_reset();
        m_phase = 0; m_lanes = '0; m_nwr = 0; m_last_add = 0; m_k = 0; m_clean = 1'b1;
    endtask

    task automatic model_check();
        bit fire;
        int base;
        fire = (m_phase == 1) && in_valid;
        base = 2 * (m_k / NW) * MAP_DIM + 2 * (m_k % NW);
        chk("m_in_ready", 32'(in_ready), 32'(m_phase == 1));
        chk("m_wr_ctrl", Wr_ctrl, fire ? m_lanes : 32'h0);
        chk("m_add_in", 32'(add_in), fire ? m_nwr : m_last_add);
        chk("m_rd_valid", 32'(rd_valid), 32'(m_phase == 2));
        chk("m_win_last", 32'(win_last), 32'((m_phase == 2) && (m_k == N_WIN - 1)));
        chk("m_busy", 32'(busy), 32'(m_phase != 0));
        chk("m_done", 32'(done), 32'(m_phase == 3));
        if (m_phase == 2) begin
            chk("m_add_1", 32'(add_1), base);
            chk("m_add_2", 32'(add_2), base + 1);
            chk("m_add_3", 32'(add_3), base + MAP_DIM);
            chk("m_add_4", 32'(add_4), base + MAP_DIM + 1);
        end else if (m_clean) begin
            chk("m_add_rst", {add_1, add_2, add_3, add_4}, 32'h0);
        end
    endtask

    task automatic model_update();
        if (rst) begin
            model_reset();
        end else begin
            case (m_phase)
                0: if (start) begin m_phase = 1; m_lanes = lane_en; m_nwr = 0; end
                1: if (in_valid) begin
                    m_last_add = m_nwr;
                    m_nwr++;
                    if (m_nwr == N_ELEM) begin m_phase = 2; m_k = 0; m_clean = 1'b0; end
                end
                2: if (rd_ready) begin
                    if (m_k == N_WIN - 1) m_phase = 3;
                    else m_k++;
                end
                default: m_phase = 0;
            endcase
        end
    endtask

    // Called at posedge+1: apply inputs, then check at the falling edge.
    task automatic drive(input logic r, input logic s, input logic [31:0] le,
                         input logic iv, input logic rr);
        rst = r; start = s; lane_en = le; in_valid = iv; rd_ready = rr;
        #4;
        if (Wr_ctrl != '0) dut_writes++;
`ifndef OB_CTRL_PINGPONG_EN
        model_check();
`endif
    endtask

    task automatic adv();
        @(posedge clk);
`ifndef OB_CTRL_PINGPONG_EN
        model_update();
`endif
        #1;
    endtask

    typedef struct {
        logic s; logic [31:0] le; logic iv; logic rr;
        logic ir; logic [31:0] wr; int ain; logic rv;
        int a1; int a2; int a3; int a4;
        logic wl; logic bz; logic dn;
    } vec_t;

    function automatic vec_t mk(input logic s, input logic [31:0] le, input logic iv, rr, ir,
                                input logic [31:0] wr, input int ain, input logic rv,
                                input int a1, a2, a3, a4, input logic wl, bz, dn);
        vec_t v;
        v.s = s; v.le = le; v.iv = iv; v.rr = rr; v.ir = ir; v.wr = wr; v.ain = ain; v.rv = rv;
        v.a1 = a1; v.a2 = a2; v.a3 = a3; v.a4 = a4; v.wl = wl; v.bz = bz; v.dn = dn;
        return v;
    endfunction

    vec_t tbl[$];
    logic iv_t;
    bit   seen;
    int   ndone;

    initial begin
        model_reset();
        @(posedge clk); #1;
        drive(1, 0, '0, 0, 0); adv();
`ifdef OB_CTRL_PINGPONG_EN
        drive(0, 1, '1, 0, 0); adv();
        for (int i = 0; i < N_ELEM; i++) begin drive(0, 0, '0, 1, 0); adv(); end
        drive(0, 1, '1, 0, 0);
        chk("pp_bank0_first", 32'(add_1), 0);
        chk("pp_rd_valid", 32'(rd_valid), 1);
        adv();
        for (int i = 0; i < N_ELEM; i++) begin
            drive(0, 0, '0, 1, 0);
            chk($sformatf("pp_fill_addr%0d", i), 32'(add_in), N_ELEM + i);
            chk($sformatf("pp_drain_hold%0d", i), 32'(add_1), 0);
            adv();
        end
        seen = 1'b0; ndone = 0;
        for (int n = 0; n < 40; n++) begin
            drive(0, 0, '0, 0, 1);
            if (done) ndone++;
            if (rd_valid && add_1 == ADDR_W'(N_ELEM) && !seen) begin
                seen = 1'b1;
                chk("pp_bank1_add2", 32'(add_2), N_ELEM + 1);
                chk("pp_bank1_add3", 32'(add_3), N_ELEM + MAP_DIM);
                chk("pp_bank1_add4", 32'(add_4), N_ELEM + MAP_DIM + 1);
            end
            adv();
        end
        chk("pp_bank1_seen", 32'(seen), 1);
        chk("pp_done_count", ndone, 2);
`else
        // Basic fill and drain, all lanes, streaming with rd_ready high.
        tbl.push_back(mk(1, '1, 0, 0, 0, '0, 0, 0, -1, -1, -1, -1, 0, 0, 0));
        for (int i = 0; i < N_ELEM; i++)
            tbl.push_back(mk(0, '0, 1, 0, 1, '1, i, 0, -1, -1, -1, -1, 0, 1, 0));
        tbl.push_back(mk(0, '0, 1, 1, 0, '0, 15, 1, 0, 1, 4, 5, 0, 1, 0));
        tbl.push_back(mk(0, '0, 1, 1, 0, '0, 15, 1, 2, 3, 6, 7, 0, 1, 0));
        tbl.push_back(mk(0, '0, 1, 1, 0, '0, 15, 1, 8, 9, 12, 13, 0, 1, 0));
        tbl.push_back(mk(0, '0, 1, 1, 0, '0, 15, 1, 10, 11, 14, 15, 1, 1, 0));
        tbl.push_back(mk(1, '1, 1, 1, 0, '0, 15, 0, -1, -1, -1, -1, 0, 1, 1));
        tbl.push_back(mk(0, '0, 0, 0, 0, '0, 15, 0, -1, -1, -1, -1, 0, 0, 0));
        for (int i = 0; i < tbl.size(); i++) begin
            drive(0, tbl[i].s, tbl[i].le, tbl[i].iv, tbl[i].rr);
            chk($sformatf("tbl%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].ir));
            chk($sformatf("tbl%0d_wr_ctrl", i), Wr_ctrl, tbl[i].wr);
            chk($sformatf("tbl%0d_add_in", i), 32'(add_in), tbl[i].ain);
            chk($sformatf("tbl%0d_rd_valid", i), 32'(rd_valid), 32'(tbl[i].rv));
            chk($sformatf("tbl%0d_win_last", i), 32'(win_last), 32'(tbl[i].wl));
            chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].bz));
            chk($sformatf("tbl%0d_done", i), 32'(done), 32'(tbl[i].dn));
            if (tbl[i].a1 >= 0) begin
                chk($sformatf("tbl%0d_add_1", i), 32'(add_1), tbl[i].a1);
                chk($sformatf("tbl%0d_add_2", i), 32'(add_2), tbl[i].a2);
                chk($sformatf("tbl%0d_add_3", i), 32'(add_3), tbl[i].a3);
                chk($sformatf("tbl%0d_add_4", i), 32'(add_4), tbl[i].a4);
            end
            adv();
        end

        // Reset held three cycles in the middle of a fill.
        drive(0, 1, '1, 0, 0); adv();
        for (int i = 0; i < 5; i++) begin drive(0, 0, '1, 1, 0); adv(); end
        ndone = 0;
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, '1, 1, 1);
            if (done) ndone++;
            if (i > 0) begin
                chk("rst_busy", 32'(busy), 0);
                chk("rst_in_ready", 32'(in_ready), 0);
                chk("rst_wr_ctrl", Wr_ctrl, 0);
                chk("rst_add_in", 32'(add_in), 0);
                chk("rst_rd_valid", 32'(rd_valid), 0);
                chk("rst_adds", {add_1, add_2, add_3, add_4}, 0);
            end
            adv();
        end
        drive(0, 1, '1, 1, 0);
        if (done) ndone++;
        chk("rst_no_done", ndone, 0);
        chk("rst_restart_busy", 32'(busy), 0);
        adv();
        drive(0, 0, '0, 1, 0);
        chk("rst_refill_addr", 32'(add_in), 0);
        chk("rst_refill_wr", Wr_ctrl, '1);
        adv();
        for (int i = 0; i < N_ELEM - 1; i++) begin drive(0, 0, '0, 1, 0); adv(); end
        for (int i = 0; i < N_WIN + 1; i++) begin drive(0, 0, '0, 0, 1); adv(); end

        // Backpressure on the third window.
        drive(0, 1, '1, 0, 0); adv();
        for (int i = 0; i < N_ELEM; i++) begin drive(0, 0, '0, 1, 0); adv(); end
        drive(0, 0, '0, 0, 1); adv();
        drive(0, 0, '0, 0, 1); adv();
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, '0, 0, 0);
            chk("bp_rd_valid", 32'(rd_valid), 1);
            chk("bp_add_1", 32'(add_1), 8);
            chk("bp_add_2", 32'(add_2), 9);
            chk("bp_add_3", 32'(add_3), 12);
            chk("bp_add_4", 32'(add_4), 13);
            adv();
        end
        drive(0, 0, '0, 0, 1); chk("bp_resume_add_1", 32'(add_1), 8); adv();
        drive(0, 0, '0, 0, 1);
        chk("bp_last_add_1", 32'(add_1), 10);
        chk("bp_last_add_4", 32'(add_4), 15);
        chk("bp_win_last", 32'(win_last), 1);
        adv();
        drive(0, 0, '0, 0, 0); chk("bp_done", 32'(done), 1); adv();

        // Partial lane mask with gaps in in_valid.
        drive(0, 1, 32'h0000_00F0, 0, 0); adv();
        dut_writes = 0;
        for (int i = 0; i < 2 * N_ELEM; i++) begin
            iv_t = (i % 2 == 0);
            drive(0, 0, '1, iv_t, 0);
            chk("mask_wr_ctrl", Wr_ctrl, iv_t ? 32'h0000_00F0 : 32'h0);
            adv();
        end
        drive(0, 0, '0, 1, 0);
        chk("mask_write_count", dut_writes, N_ELEM);
        chk("mask_in_ready_drop", 32'(in_ready), 0);
        adv();
        for (int i = 0; i < N_WIN + 1; i++) begin drive(0, 0, '0, 0, 1); adv(); end

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            drive($urandom_range(0, 99) == 0, $urandom_range(0, 7) == 0, $urandom,
                  $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1);
            adv();
        end
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/output_buffer_ctrl.md
Name: output_buffer_ctrl

Overview:
- Sequencer for the per-channel register-file output buffer; sits between the PE array and the 2x2 pooling stage.
- FILL phase: accepts one row-major feature-map element per handshake (all WIDTH channels in parallel) and generates the write enables and write address.
- DRAIN phase: walks the map in 2x2 windows and drives the four read addresses, so the pooling stage gets a full window each handshake.

Parameters:
- WIDTH, 32, number of channel lanes (one register file per lane).
- ADDR_W, 5, register-file address width (32 entries).
- MAP_DIM, 4, feature-map side length; must be even, and MAP_DIM*MAP_DIM <= 2**ADDR_W (halved with ping-pong).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a FILL; ignored unless in IDLE (or ping-pong rules apply).
- lane_en  in  WIDTH  lanes that take part; sampled on start.
- in_valid  in  1  PE output element valid.
- in_ready  out  1  controller accepts an element.
- Wr_ctrl  out  WIDTH  per-lane write enable to the buffer.
- add_in  out  ADDR_W  write address (broadcast to all lanes).
- rd_valid  out  1  read window addresses valid.
- rd_ready  in  1  pooling stage consumes the window.
- add_1  out  ADDR_W  window top-left address.
- add_2  out  ADDR_W  window top-right address.
- add_3  out  ADDR_W  window bottom-left address.
- add_4  out  ADDR_W  window bottom-right address.
- win_last  out  1  current window is the final one of the map.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse after the last window handshake.

Behaviour:
- Reset (rst=1 at a clock edge):
  - State goes to IDLE; all counters clear.
  - All outputs 0: in_ready, Wr_ctrl, add_in, rd_valid, add_1..4, win_last, busy, done.
  - Reset during FILL or DRAIN abandons the operation; no done pulse.
- States: IDLE -> FILL -> DRAIN -> DONE -> IDLE.
- IDLE:
  - start=1 latches lane_en, clears wr_cnt, goes to FILL.
  - busy rises the cycle after start.
- FILL:
  - in_ready=1.
  - Write fires when in_valid && in_ready. In that same cycle, combinationally: Wr_ctrl = latched lane_en, add_in = wr_cnt.
  - Otherwise Wr_ctrl=0. add_in holds its last value.
  - wr_cnt increments per write.
  - On the write with wr_cnt = MAP_DIM*MAP_DIM-1: next state DRAIN; in_ready drops the next cycle.
- DRAIN:
  - Window counters wr, wc range 0..MAP_DIM/2-1, row-major.
  - Addresses are registered and valid in the first DRAIN cycle:
    - add_1 = 2*wr*MAP_DIM + 2*wc
    - add_2 = add_1 + 1
    - add_3 = add_1 + MAP_DIM
    - add_4 = add_1 + MAP_DIM + 1
    - Computed at ADDR_W bits; the legal parameter range guarantees no overflow.
  - rd_valid=1 throughout DRAIN.
  - rd_valid and add_1..4 hold stable while rd_ready=0.
  - On a handshake, the next window's addresses appear the following cycle, so zero-bubble streaming is possible.
  - win_last=1 while wr = wc = MAP_DIM/2-1.
  - The handshake on the last window goes to DONE.
- DONE: done=1 for exactly one cycle, rd_valid=0, then IDLE.
- Register-file reads are combinational: the consumer samples out1..out4 in the cycle rd_valid && rd_ready.
- Simultaneous events:
  - start outside IDLE is ignored.
  - in_valid outside FILL is ignored: no write, in_ready=0.
  - rd_ready outside DRAIN is ignored.

Optional Feature:
- Macro: OB_CTRL_PINGPONG_EN.
- Defined:
  - Address space splits into two banks of MAP_DIM*MAP_DIM entries; bank bit = address MSB.
  - add_in carries the fill bank; add_1..4 carry the drain bank.
  - FILL and DRAIN run concurrently as independent sub-FSMs. After a fill completes, its bank is queued for draining.
  - start is accepted while a drain is in progress if the other bank is free.
  - in_ready=0 when both banks are full or awaiting drain.
  - done pulses per drained bank.
  - Banks alternate starting at bank 0 after reset.
  - Requires 2*MAP_DIM*MAP_DIM <= 2**ADDR_W.
- Undefined: single bank, strictly serial behaviour as above.

Test Plan:
- Reset/idle: hold rst 3 cycles mid-FILL -> all outputs 0, busy=0; a following start with in_valid=1 writes from add_in=0 again.
- Basic fill (MAP_DIM=4, lane_en=32'hFFFF_FFFF): start, then 16 back-to-back in_valid -> Wr_ctrl all-ones on 16 cycles, add_in 0..15, in_ready=0 after the 16th write.
- Drain order with rd_ready=1: windows (0,1,4,5), (2,3,6,7), (8,9,12,13), (10,11,14,15) on 4 consecutive cycles; win_last on the 4th; done the next cycle.
- Backpressure: rd_ready low for 5 cycles on window 2 -> add_1..4 hold 8,9,12,13 and rd_valid stays 1; the sequence then resumes unchanged.
- Lane mask and gaps: lane_en=32'h0000_00F0, in_valid toggling 1/0 -> Wr_ctrl=32'h0000_00F0 only on valid cycles, add_in increments only on writes, total 16 writes.
- Ping-pong (macro on): second start during the drain of bank 0 -> fill writes addresses 16..31 while add_1..4 stay in 0..15; the next drain yields the first window (16,17,20,21); two done pulses total.
